camera_pixel_assembler: RTL and testbench

- Parametrised successor to the camera byte-to-pixel reconstruction stage; sits between the camera input pins (pre-synchronised into clk_in) and the frame buffer/detection pipeline.
- Packs BYTES_PER_PIXEL data samples per pixel with selectable byte order, and tracks source line/frame position.
- Adds power-of-two decimation, frame-start and line-done flags, measured line length, and a partial-pixel error flag.

---
 rtl/camera_pixel_assembler.sv | 128 ++++++++++++
 tb/tb_camera_pixel_assembler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_pixel_assembler.sv
// Camera byte-to-pixel assembler: packs BYTES_PER_PIXEL samples per pixel, tracks source
// line/frame position, decimates by powers of two and reports line length and partial pixels.
module camera_pixel_assembler #(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int HCOUNT_WIDTH    = 11,
  parameter int VCOUNT_WIDTH    = 10,
  parameter int FIRST_IN_MSB    = 1,
  parameter int HSKIP_LOG2      = 0,
  parameter int VSKIP_LOG2      = 0
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  camera_pclk_in,
  input  logic                                  camera_hs_in,
  input  logic                                  camera_vs_in,
  input  logic [DATA_WIDTH-1:0]                 camera_data_in,
  output logic                                  pixel_valid_out,
  output logic [HCOUNT_WIDTH-1:0]               pixel_hcount_out,
  output logic [VCOUNT_WIDTH-1:0]               pixel_vcount_out,
  output logic [BYTES_PER_PIXEL*DATA_WIDTH-1:0] pixel_data_out,
  output logic                                  frame_start_out,
  output logic                                  line_done_out,
  output logic [HCOUNT_WIDTH-1:0]               line_length_out,
  output logic                                  partial_error_out
);

  localparam int PW    = BYTES_PER_PIXEL * DATA_WIDTH;
  localparam int IDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_MASK   = HCOUNT_WIDTH'((1 << HSKIP_LOG2) - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_MASK   = VCOUNT_WIDTH'((1 << VSKIP_LOG2) - 1);

  logic                    pclk_prev;
  logic [IDX_W-1:0]        byte_idx;
  logic [HCOUNT_WIDTH-1:0] src_h;
  logic [VCOUNT_WIDTH-1:0] src_v;
  logic                    line_active;
  logic                    frame_first;
  logic [PW-1:0]           pix_sr;
  logic [PW-1:0]           pix_next;
  logic                    strobe;
  logic                    emit_ok;

  assign strobe  = !pclk_prev && camera_pclk_in;
  assign emit_ok = ((src_h & H_MASK) == '0) && ((src_v & V_MASK) == '0);

  // Shift register with the current sample dropped into its byte slot, so the final
  // byte of a pixel can be emitted on the same edge it is captured.
  always_comb begin
    pix_next = pix_sr;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (byte_idx == IDX_W'(k)) begin
        if (FIRST_IN_MSB != 0)
          pix_next[(BYTES_PER_PIXEL-1-k)*DATA_WIDTH +: DATA_WIDTH] = camera_data_in;
        else
          pix_next[k*DATA_WIDTH +: DATA_WIDTH] = camera_data_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    pclk_prev <= camera_pclk_in;
    if (rst_in) begin
      byte_idx          <= '0;
      src_h             <= '0;
      src_v             <= '0;
      line_active       <= 1'b0;
      frame_first       <= 1'b1;
      pix_sr            <= '0;
      pixel_valid_out   <= 1'b0;
      pixel_hcount_out  <= '0;
      pixel_vcount_out  <= '0;
      pixel_data_out    <= '0;
      frame_start_out   <= 1'b0;
      line_done_out     <= 1'b0;
      line_length_out   <= '0;
      partial_error_out <= 1'b0;
    end else begin
      pixel_valid_out   <= 1'b0;
      frame_start_out   <= 1'b0;
      line_done_out     <= 1'b0;
      partial_error_out <= 1'b0;
      if (strobe) begin
        if (camera_vs_in && camera_hs_in) begin
          pix_sr      <= pix_next;
          line_active <= 1'b1;
          if (byte_idx == LAST_IDX) begin
            byte_idx <= '0;
            src_h    <= src_h + 1'b1;
            if (emit_ok) begin
              pixel_valid_out  <= 1'b1;
              pixel_data_out   <= pix_next;
              pixel_hcount_out <= src_h >> HSKIP_LOG2;
              pixel_vcount_out <= src_v >> VSKIP_LOG2;
              frame_start_out  <= frame_first;
              frame_first      <= 1'b0;
            end
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end else begin
          // Line end is reported both on hs fall and on vs fall mid-line.
          if (line_active) begin
            line_done_out     <= 1'b1;
            line_length_out   <= src_h;
            partial_error_out <= (byte_idx != '0);
          end
          if (camera_vs_in) begin
            if (line_active) begin
              src_v       <= src_v + 1'b1;
              src_h       <= '0;
              byte_idx    <= '0;
              line_active <= 1'b0;
            end
          end else begin
            src_h       <= '0;
            src_v       <= '0;
            byte_idx    <= '0;
            line_active <= 1'b0;
            frame_first <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Bench for camera_pixel_assembler: three parameterisations share one camera stream and are
// compared every cycle against a byte/line-count model, plus literal expectations on that model.
module tb_camera_pixel_assembler;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       camera_pclk_in = 1'b0;
  logic       camera_hs_in = 1'b0;
  logic       camera_vs_in = 1'b0;
  logic [7:0] camera_data_in = 8'h00;

  always #5 clk_in = ~clk_in;

  // u0: defaults; u1: 3 bytes LSB-first, 2x2 decimation; u2: 1 byte, tiny counters to force wrap.
  logic        v0, fs0, ld0, pe0;
  logic [10:0] h0, len0;
  logic [9:0]  vc0;
  logic [15:0] d0;
  logic        v1, fs1, ld1, pe1;
  logic [10:0] h1, len1;
  logic [9:0]  vc1;
  logic [23:0] d1;
  logic        v2, fs2, ld2, pe2;
  logic [2:0]  h2, len2;
  logic [1:0]  vc2;
  logic [7:0]  d2;

  camera_pixel_assembler u0 (
    .clk_in(clk_in), .rst_in(rst_in), .camera_pclk_in(camera_pclk_in),
    .camera_hs_in(camera_hs_in), .camera_vs_in(camera_vs_in), .camera_data_in(camera_data_in),
    .pixel_valid_out(v0), .pixel_hcount_out(h0), .pixel_vcount_out(vc0), .pixel_data_out(d0),
    .frame_start_out(fs0), .line_done_out(ld0), .line_length_out(len0), .partial_error_out(pe0));

  camera_pixel_assembler #(.BYTES_PER_PIXEL(3), .FIRST_IN_MSB(0), .HSKIP_LOG2(1), .VSKIP_LOG2(1)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .camera_pclk_in(camera_pclk_in),
    .camera_hs_in(camera_hs_in), .camera_vs_in(camera_vs_in), .camera_data_in(camera_data_in),
    .pixel_valid_out(v1), .pixel_hcount_out(h1), .pixel_vcount_out(vc1), .pixel_data_out(d1),
    .frame_start_out(fs1), .line_done_out(ld1), .line_length_out(len1), .partial_error_out(pe1));

  camera_pixel_assembler #(.BYTES_PER_PIXEL(1), .HCOUNT_WIDTH(3), .VCOUNT_WIDTH(2), .VSKIP_LOG2(1)) u2 (
    .clk_in(clk_in), .rst_in(rst_in), .camera_pclk_in(camera_pclk_in),
    .camera_hs_in(camera_hs_in), .camera_vs_in(camera_vs_in), .camera_data_in(camera_data_in),
    .pixel_valid_out(v2), .pixel_hcount_out(h2), .pixel_vcount_out(vc2), .pixel_data_out(d2),
    .frame_start_out(fs2), .line_done_out(ld2), .line_length_out(len2), .partial_error_out(pe2));

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Model parameters per instance.
  int m_b[3]   = '{2, 3, 1};
  int m_msb[3] = '{1, 0, 1};
  int m_hs[3]  = '{0, 1, 0};
  int m_vs[3]  = '{0, 1, 1};
  int m_hw[3]  = '{11, 11, 3};
  int m_vw[3]  = '{10, 10, 2};

  // Model state: bytes so far in the current pixel, pixels so far in the line, lines so far in the frame.
  int         cnt[3], pix[3], line_no[3];
  bit         in_line[3], first[3];
  logic [7:0] bytes[3][4];
  bit         m_prev, m_stb;

  bit          e_valid[3], e_fs[3], e_ld[3], e_pe[3];
  int          e_h[3], e_v[3], e_len[3];
  logic [31:0] e_data[3];

  typedef struct packed {
    logic        fs;
    logic [15:0] h;
    logic [15:0] v;
    logic [31:0] d;
  } px_t;
  px_t         px_log[3][$];
  logic [16:0] ld_log[3][$];

  function automatic void model_step(int i);
    int p, l;
    logic [31:0] data;
    if (camera_vs_in && camera_hs_in) begin
      bytes[i][cnt[i]] = camera_data_in;
      cnt[i]++;
      in_line[i] = 1'b1;
      if (cnt[i] == m_b[i]) begin
        p = pix[i] % (1 << m_hw[i]);
        l = line_no[i] % (1 << m_vw[i]);
        if ((p % (1 << m_hs[i])) == 0 && (l % (1 << m_vs[i])) == 0) begin
          data = 32'h0;
          for (int k = 0; k < m_b[i]; k++) begin
            if (m_msb[i] != 0) data |= 32'(bytes[i][k]) << (8 * (m_b[i] - 1 - k));
            else               data |= 32'(bytes[i][k]) << (8 * k);
          end
          e_valid[i] = 1'b1;
          e_fs[i]    = first[i];
          first[i]   = 1'b0;
          e_h[i]     = p >> m_hs[i];
          e_v[i]     = l >> m_vs[i];
          e_data[i]  = data;
          px_log[i].push_back({e_fs[i], 16'(e_h[i]), 16'(e_v[i]), data});
        end
        pix[i]++;
        cnt[i] = 0;
      end
    end else begin
      if (in_line[i]) begin
        e_ld[i]  = 1'b1;
        e_len[i] = pix[i] % (1 << m_hw[i]);
        e_pe[i]  = (cnt[i] != 0);
        ld_log[i].push_back({e_pe[i], 16'(e_len[i])});
      end
      if (camera_vs_in) begin
        if (in_line[i]) begin
          line_no[i]++;
          pix[i] = 0; cnt[i] = 0; in_line[i] = 1'b0;
        end
      end else begin
        line_no[i] = 0; pix[i] = 0; cnt[i] = 0; in_line[i] = 1'b0; first[i] = 1'b1;
      end
    end
  endfunction

  always @(posedge clk_in) begin
    m_stb  = !m_prev && camera_pclk_in;
    m_prev = camera_pclk_in;
    for (int i = 0; i < 3; i++) begin
      e_valid[i] = 1'b0; e_fs[i] = 1'b0; e_ld[i] = 1'b0; e_pe[i] = 1'b0;
      if (rst_in) begin
        cnt[i] = 0; pix[i] = 0; line_no[i] = 0; in_line[i] = 1'b0; first[i] = 1'b1;
        e_h[i] = 0; e_v[i] = 0; e_len[i] = 0; e_data[i] = 32'h0;
      end else if (m_stb) begin
        model_step(i);
      end
    end
  end

  function automatic logic [83:0] exp_pack(int i);
    return {e_valid[i], e_fs[i], e_ld[i], e_pe[i], 16'(e_h[i]), 16'(e_v[i]), 16'(e_len[i]), e_data[i]};
  endfunction

  task automatic cmp_cycle(input int i, input logic [83:0] act);
    logic [83:0] exp;
    exp = exp_pack(i);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cycle_u%0d t=%0t actual={v,fs,ld,pe,h,v,len,data}=%h required=%h", i, $time, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (checking) begin
      cmp_cycle(0, {v0, fs0, ld0, pe0, 16'(h0), 16'(vc0), 16'(len0), 32'(d0)});
      cmp_cycle(1, {v1, fs1, ld1, pe1, 16'(h1), 16'(vc1), 16'(len1), 32'(d1)});
      cmp_cycle(2, {v2, fs2, ld2, pe2, 16'(h2), 16'(vc2), 16'(len2), 32'(d2)});
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      px_log[i].delete();
      ld_log[i].delete();
    end
  endtask

  // One camera sample: pclk low for a few cycles, then a rising edge carrying vs/hs/data,
  // then pclk held high (occasionally for a long stretch) while data wanders.
  task automatic strobe(input logic vs, input logic hs, input logic [7:0] d);
    int lo, hi;
    lo = $urandom_range(1, 3);
    hi = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 3);
    for (int k = 0; k < lo; k++) begin
      @(posedge clk_in); #1;
      camera_pclk_in = 1'b0;
      camera_data_in = 8'($urandom);
    end
    @(posedge clk_in); #1;
    camera_pclk_in = 1'b1;
    camera_vs_in   = vs;
    camera_hs_in   = hs;
    camera_data_in = d;
    for (int k = 0; k < hi; k++) begin
      @(posedge clk_in); #1;
      camera_data_in = 8'($urandom);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    repeat ($urandom_range(1, 2)) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq_a[4];
    logic [7:0] seq_b[3];
    seq_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    seq_b = '{8'h11, 8'h22, 8'h33};

    @(posedge clk_in); #1;
    checking = 1'b1;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    chk("reset_u0", {v0, fs0, ld0, pe0, 16'(h0), 16'(vc0), 16'(len0), 32'(d0)}, 65'd0);
    rst_in = 1'b0;

    // A: one line A1 B2 C3 D4
    strobe(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) strobe(1'b1, 1'b1, seq_a[k]);
    strobe(1'b1, 1'b0, 8'h00);
    chk("a_u0_count", 65'(px_log[0].size()), 65'd2);
    chk("a_u0_px0", px_log[0][0], {1'b1, 16'd0, 16'd0, 32'hA1B2});
    chk("a_u0_px1", px_log[0][1], {1'b0, 16'd1, 16'd0, 32'hC3D4});
    chk("a_u0_line", 65'(ld_log[0][0]), {1'b0, 16'd2});
    chk("a_u1_px0", px_log[1][0], {1'b1, 16'd0, 16'd0, 32'hC3B2A1});
    chk("a_u1_line", 65'(ld_log[1][0]), {1'b1, 16'd1});
    clear_logs();

    // New frame: 11 22 33, then a 2-byte line to show the byte index restarts.
    strobe(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) strobe(1'b1, 1'b1, seq_b[k]);
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b1, 1'b1, 8'h55);
    strobe(1'b1, 1'b1, 8'h66);
    strobe(1'b1, 1'b0, 8'h00);
    chk("b_u1_px", px_log[1][0], {1'b1, 16'd0, 16'd0, 32'h332211});
    chk("b_u1_line", 65'(ld_log[1][0]), {1'b0, 16'd1});
    chk("b_u0_px0", px_log[0][0], {1'b1, 16'd0, 16'd0, 32'h1122});
    chk("b_u0_line", 65'(ld_log[0][0]), {1'b1, 16'd1});
    chk("b_u0_px1", px_log[0][1], {1'b0, 16'd0, 16'd1, 32'h5566});
    clear_logs();

    // C: three lines of 12 bytes -> 2x2 decimation on u1, hcount wrap on u2.
    strobe(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 12; k++) strobe(1'b1, 1'b1, 8'($urandom));
      strobe(1'b1, 1'b0, 8'h00);
    end
    chk("c_u1_count", 65'(px_log[1].size()), 65'd4);
    chk("c_u1_px0", 65'({px_log[1][0].fs, px_log[1][0].h, px_log[1][0].v}), {1'b1, 16'd0, 16'd0});
    chk("c_u1_px1", 65'({px_log[1][1].fs, px_log[1][1].h, px_log[1][1].v}), {1'b0, 16'd1, 16'd0});
    chk("c_u1_px2", 65'({px_log[1][2].fs, px_log[1][2].h, px_log[1][2].v}), {1'b0, 16'd0, 16'd1});
    chk("c_u1_px3", 65'({px_log[1][3].fs, px_log[1][3].h, px_log[1][3].v}), {1'b0, 16'd1, 16'd1});
    chk("c_u2_count", 65'(px_log[2].size()), 65'd24);
    chk("c_u2_wrap", 65'({px_log[2][8].h, px_log[2][8].v}), {16'd0, 16'd0});
    chk("c_u2_line2", 65'({px_log[2][12].h, px_log[2][12].v}), {16'd0, 16'd1});
    chk("c_u2_len", 65'(ld_log[2][0]), {1'b0, 16'd4});
    clear_logs();

    // D: vs (with hs still high) drops mid-pixel.
    strobe(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) strobe(1'b1, 1'b1, 8'($urandom));
    strobe(1'b0, 1'b1, 8'h00);
    chk("d_u0_line", 65'(ld_log[0][0]), {1'b1, 16'd1});
    chk("d_u1_line", 65'(ld_log[1][0]), {1'b0, 16'd1});
    clear_logs();

    // E: reset mid-pixel, then the stream resumes.
    strobe(1'b1, 1'b1, 8'h77);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("e_rst_u0", {v0, fs0, ld0, pe0, 16'(h0), 16'(vc0), 16'(len0), 32'(d0)}, 65'd0);
    chk("e_rst_u1", {v1, fs1, ld1, pe1, 16'(h1), 16'(vc1), 16'(len1), 32'(d1)}, 65'd0);
    rst_in = 1'b0;
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b1, 1'b1, 8'h88);
    strobe(1'b1, 1'b1, 8'h99);
    strobe(1'b1, 1'b0, 8'h00);
    chk("e_u0_px", px_log[0][0], {1'b1, 16'd0, 16'd0, 32'h8899});
    chk("e_u0_lines", 65'(ld_log[0].size()), 65'd1);
    chk("e_u0_line", 65'(ld_log[0][0]), {1'b0, 16'd1});
    clear_logs();

    // Random frames: varying line lengths, mid-line vs drops and occasional resets.
    for (int f = 0; f < 40; f++) begin
      strobe(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int l = 0; l < $urandom_range(1, 5); l++) begin
        for (int b = 0; b < $urandom_range(0, 14); b++) begin
          strobe(1'b1, 1'b1, 8'($urandom));
          if ($urandom_range(0, 199) == 0) reset_pulse();
        end
        if ($urandom_range(0, 9) == 0) strobe(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        strobe(1'b1, 1'b0, 8'($urandom));
        if ($urandom_range(0, 2) == 0) strobe(1'b1, 1'b0, 8'($urandom));
      end
    end

    repeat (4) @(posedge clk_in);
    @(negedge clk_in); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
